// File: rtl/rv32i_run_ctrl.sv
// Run-control / debug sequencer for the single-cycle RV32I core: owns core reset,
// the per-cycle commit enable, breakpoint/EBREAK halting, and a retire counter.
module rv32i_run_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES = 4,
  parameter bit          AUTO_RUN        = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        core_rst_n,
  output logic        core_en,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {ST_RESET_HOLD, ST_HALTED, ST_RUNNING} state_t;

  localparam logic [2:0] OP_HALT       = 3'd1;
  localparam logic [2:0] OP_RUN        = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_SET_BP     = 3'd4;
  localparam logic [2:0] OP_CLR_BP     = 3'd5;
  localparam logic [2:0] OP_CLR_CNT    = 3'd6;
  localparam logic [2:0] OP_RESET_CORE = 3'd7;

  localparam logic [2:0] CAUSE_RESET  = 3'd0;
  localparam logic [2:0] CAUSE_HOST   = 3'd1;
  localparam logic [2:0] CAUSE_STEP   = 3'd2;
  localparam logic [2:0] CAUSE_BP     = 3'd3;
  localparam logic [2:0] CAUSE_EBREAK = 3'd4;
  localparam logic [2:0] CAUSE_BUDGET = 3'd5;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam logic [7:0]  HOLD_LAST   = 8'(RST_HOLD_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_hold_cnt;
  logic [31:0] r_budget_left;
  logic        r_unlimited;
  logic        r_step_mode;
  logic        r_bp_en;
  logic [31:0] r_bp_addr;
  logic        r_skip_once;
  logic [2:0]  r_halt_cause;
  logic [31:0] r_retire_cnt;

  logic w_accept;
  logic w_bp_hit;
  logic w_ebreak;
  logic w_stop;

  // Only combinational path in the block: pc/instr -> core_en.
  assign w_accept = cmd_valid && cmd_ready;
  assign w_bp_hit = r_bp_en && (pc == r_bp_addr);
  assign w_ebreak = (instr == EBREAK_INSN);
  assign w_stop   = (w_bp_hit || w_ebreak) && !r_skip_once;

  assign cmd_ready  = (r_state != ST_RESET_HOLD);
  assign core_rst_n = (r_state != ST_RESET_HOLD);
  assign core_en    = (r_state == ST_RUNNING) && !w_stop;
  assign halted     = (r_state == ST_HALTED);
  assign halt_cause = r_halt_cause;
  assign retire_cnt = r_retire_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RESET_HOLD;
      r_hold_cnt    <= '0;
      r_budget_left <= '0;
      r_unlimited   <= 1'b0;
      r_step_mode   <= 1'b0;
      r_bp_en       <= 1'b0;
      r_bp_addr     <= '0;
      r_skip_once   <= 1'b0;
      r_halt_cause  <= CAUSE_RESET;
      r_retire_cnt  <= '0;
    end else begin
      if (w_accept && cmd_op == OP_CLR_CNT) r_retire_cnt <= '0;
      else if (core_en)                     r_retire_cnt <= r_retire_cnt + 32'd1;

      if (w_accept && cmd_op == OP_SET_BP) begin
        r_bp_addr <= cmd_data;
        r_bp_en   <= 1'b1;
      end else if (w_accept && cmd_op == OP_CLR_BP) begin
        r_bp_en <= 1'b0;
      end

      case (r_state)
        ST_RESET_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_halt_cause <= CAUSE_RESET;
            if (AUTO_RUN) begin
              r_state       <= ST_RUNNING;
              r_unlimited   <= 1'b1;
              r_step_mode   <= 1'b0;
              r_budget_left <= '0;
            end else begin
              r_state <= ST_HALTED;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end

        ST_HALTED: begin
          if (w_accept && (cmd_op == OP_RUN || cmd_op == OP_STEP)) begin
            r_state       <= ST_RUNNING;
            r_budget_left <= (cmd_op == OP_STEP) ? 32'd1 : cmd_data;
            r_unlimited   <= (cmd_op == OP_RUN) && (cmd_data == '0);
            r_step_mode   <= (cmd_op == OP_STEP);
            r_skip_once   <= (r_halt_cause == CAUSE_BP) || (r_halt_cause == CAUSE_EBREAK);
          end else if (w_accept && cmd_op == OP_RESET_CORE) begin
            r_state     <= ST_RESET_HOLD;
            r_hold_cnt  <= '0;
            r_skip_once <= 1'b0;
          end
        end

        ST_RUNNING: begin
          if (w_accept && cmd_op == OP_RESET_CORE) begin
            r_state     <= ST_RESET_HOLD;
            r_hold_cnt  <= '0;
            r_skip_once <= 1'b0;
          end else if (w_stop) begin
            r_state      <= ST_HALTED;
            r_halt_cause <= w_bp_hit ? CAUSE_BP : CAUSE_EBREAK;
          end else begin
            // Instruction retires this cycle; host HALT and RUN reload override budget expiry.
            r_skip_once <= 1'b0;
            if (!r_unlimited) r_budget_left <= r_budget_left - 32'd1;
            if (w_accept && cmd_op == OP_HALT) begin
              r_state      <= ST_HALTED;
              r_halt_cause <= CAUSE_HOST;
            end else if (w_accept && cmd_op == OP_RUN) begin
              r_budget_left <= cmd_data;
              r_unlimited   <= (cmd_data == '0);
            end else if (!r_unlimited && r_budget_left == 32'd1) begin
              r_state      <= ST_HALTED;
              r_halt_cause <= r_step_mode ? CAUSE_STEP : CAUSE_BUDGET;
            end
          end
        end

        default: r_state <= ST_RESET_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Scoreboard bench for rv32i_run_ctrl: a tiny core model steps pc by 4 (looping
// over 0x00..0x1C) whenever core_en is high; halts are checked against a queue.
module tb_rv32i_run_ctrl;

  localparam logic [2:0] OP_HALT = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3, OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5, OP_CLR_CNT = 3'd6, OP_RESET_CORE = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        core_rst_n;
  logic        core_en;
  logic        halted;
  logic [2:0]  halt_cause;
  logic [31:0] retire_cnt;

  logic        eb_en;
  logic [31:0] eb_addr;

  typedef struct {
    logic [2:0]  cause;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int en_pulses = 0;
  logic prev_halted = 1'b0;

  rv32i_run_ctrl #(.RST_HOLD_CYCLES(4), .AUTO_RUN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pc(pc), .instr(instr),
    .core_rst_n(core_rst_n), .core_en(core_en), .halted(halted),
    .halt_cause(halt_cause), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!core_rst_n)  pc <= 32'h0;
    else if (core_en) pc <= (pc + 32'd4) & 32'h1F;
  end

  always_comb instr = (eb_en && pc == eb_addr) ? 32'h0010_0073 : 32'h0000_0013;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every halt entry pops one expected (cause, retire count) pair.
  always @(negedge clk) begin
    exp_t e;
    if (!core_rst_n) check("en_in_core_reset", {31'b0, core_en}, 32'd0);
    if (core_en) en_pulses++;
    if (halted && !prev_halted) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_halt: cause %0d with empty scoreboard", halt_cause);
      end else begin
        e = sb_q.pop_front();
        check("halt_cause", {29'b0, halt_cause}, {29'b0, e.cause});
        check("retire_at_halt", retire_cnt, e.cnt);
      end
    end
    prev_halted = halted;
  end

  task automatic push(input logic [2:0] cause, input logic [31:0] cnt);
    exp_t e;
    e.cause = cause;
    e.cnt   = cnt;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 32'd0;
  endtask

  task automatic count_hold(output int n);
    n = 0;
    while (!core_rst_n && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, "_halt_timeout"}, {31'b0, halted}, 32'd1);
  endtask

  task automatic check_reset_state();
    check("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("rst_core_en", {31'b0, core_en}, 32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_cause", {29'b0, halt_cause}, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int e0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 32'd0;
    eb_en = 1'b0; eb_addr = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_state();

    push(3'd0, 32'd0);
    rst_n = 1'b1;
    count_hold(n);
    check("hold_after_rst_n", n, 32'd4);
    wait_halt("reset_release");
    check("ready_when_halted", {31'b0, cmd_ready}, 32'd1);

    e0 = en_pulses;
    push(3'd5, 32'd5);
    send(OP_RUN, 32'd5);
    wait_halt("run5");
    check("run5_pulses", en_pulses - e0, 32'd5);

    for (int i = 0; i < 3; i++) begin
      push(3'd2, 32'd6 + i);
      send(OP_STEP, 32'd0);
      wait_halt("step");
    end
    check("pc_after_steps", pc, 32'h0);

    send(OP_SET_BP, 32'h10);
    push(3'd3, 32'd12);
    send(OP_RUN, 32'd0);
    wait_halt("bp_first");
    check("bp_pc", pc, 32'h10);
    check("bp_core_en", {31'b0, core_en}, 32'd0);

    push(3'd3, 32'd20);
    send(OP_RUN, 32'd0);
    wait_halt("bp_resume");
    check("bp_resume_pc", pc, 32'h10);

    send(OP_CLR_BP, 32'd0);
    push(3'd0, 32'd20);
    send(OP_RESET_CORE, 32'd0);
    count_hold(n);
    check("hold_after_reset_core", n, 32'd4);
    wait_halt("reset_core");

    eb_en = 1'b1; eb_addr = 32'h08;
    push(3'd4, 32'd22);
    send(OP_RUN, 32'd0);
    wait_halt("ebreak");
    check("ebreak_pc", pc, 32'h08);

    send(OP_SET_BP, 32'h08);
    push(3'd0, 32'd22);
    send(OP_RESET_CORE, 32'd0);
    wait_halt("reset_core2");
    push(3'd3, 32'd24);
    send(OP_RUN, 32'd0);
    wait_halt("bp_over_ebreak");

    send(OP_CLR_BP, 32'd0);
    eb_en = 1'b0;
    send(OP_CLR_CNT, 32'd0);
    check("clr_cnt_1", retire_cnt, 32'd0);
    push(3'd1, 32'd2);
    send(OP_RUN, 32'd0);
    send(OP_HALT, 32'd0);
    wait_halt("host_halt");
    check("host_halt_pc", pc, 32'h10);

    send(OP_HALT, 32'd0);
    repeat (2) @(negedge clk);
    check("halt_when_halted", {31'b0, halted}, 32'd1);
    check("halt_when_halted_cause", {29'b0, halt_cause}, 32'd1);

    send(OP_CLR_CNT, 32'd0);
    check("clr_cnt_2", retire_cnt, 32'd0);
    send(OP_RUN, 32'd0);
    send(OP_RESET_CORE, 32'd0);
    check("retire_kept_reset_core", retire_cnt, 32'd2);
    check("reset_core_midrun", {31'b0, core_rst_n}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state();
    push(3'd0, 32'd0);
    rst_n = 1'b1;
    count_hold(n);
    check("hold_after_midhold_rst", n, 32'd4);
    wait_halt("final_reset");

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_run_ctrl.md
# rv32i_run_ctrl

Run-control and debug sequencer for the single-cycle RV32I core. It owns the core's reset and a per-cycle commit enable that gates PC update, register-file write and data-memory store. Under host commands it holds, runs, single-steps, or runs the core for a bounded instruction budget. It halts on a PC breakpoint or an EBREAK, and counts retired instructions.

## Interface
Parameters:
- RST_HOLD_CYCLES, 4: cycles `core_rst_n` stays low after `rst_n` deasserts or after a RESET_CORE command; legal range 1..255.
- AUTO_RUN, 0: 1 means leave RESET_HOLD into RUNNING with an unlimited budget; 0 means leave it into HALTED.

Ports:
- clk  in  1  clock; everything is updated on the rising edge.
- rst_n  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`.
- cmd_valid  in  1  host command strobe.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 RESET_CORE.
- cmd_data  in  32  RUN: instruction budget (0 = unlimited). SET_BP: breakpoint address. Ignored for all other commands.
- pc  in  32  current core PC.
- instr  in  32  current fetched instruction.
- core_rst_n  out  1  active-low reset to the core's PC register.
- core_en  out  1  commit enable for the current instruction.
- halted  out  1  state is HALTED.
- halt_cause  out  3  0 reset, 1 host HALT, 2 step done, 3 breakpoint, 4 EBREAK, 5 budget exhausted.
- retire_cnt  out  32  count of cycles with `core_en` = 1; wraps modulo 2^32.

## Operation
- States: RESET_HOLD, HALTED, RUNNING.
- Registered state: `hold_cnt`, `budget_left` (32b), `unlimited`, `step_mode`, `bp_en`, `bp_addr`, `skip_once`.
- RESET_HOLD:
  - `core_rst_n` = 0, `core_en` = 0, `cmd_ready` = 0.
  - `hold_cnt` counts to RST_HOLD_CYCLES, then the block moves to HALTED (cause 0) or to RUNNING (if AUTO_RUN).
- HALTED: `core_en` = 0, `cmd_ready` = 1.
- RUNNING:
  - `stop_now` = (`bp_en` and `pc` == `bp_addr`, or `instr` == 32'h00100073) and not `skip_once`.
  - `core_en` = not `stop_now`. This is the only combinational path, from `pc`/`instr` to `core_en`.
  - If `stop_now`: go to HALTED with cause 3 (breakpoint) or 4 (EBREAK). Breakpoint wins if both match. Nothing retires that cycle.
  - Otherwise the instruction retires and `skip_once` clears.
  - Budget: if not unlimited, `budget_left` decrements on retire. On the 1→0 transition, go to HALTED with cause 2 if `step_mode`, else cause 5.
- Command accept: `cmd_valid` and `cmd_ready`. One command per cycle. Its effect is visible after that edge.
- HALT:
  - RUNNING: go to HALTED, cause 1. An instruction already enabled in the accept cycle still retires.
  - HALTED: no-op; cause unchanged.
- RUN:
  - HALTED: go to RUNNING. Load `budget_left` = `cmd_data`; `unlimited` = (`cmd_data` == 0); `step_mode` = 0.
  - RUNNING: reload the budget only.
- STEP:
  - HALTED: same as RUN with budget 1, `step_mode` = 1.
  - RUNNING: ignored.
- `skip_once` is set when leaving HALTED via RUN or STEP and the previous cause was 3 or 4. This lets the stopped instruction execute once on resume.
- SET_BP: `bp_addr` = `cmd_data`, `bp_en` = 1. CLR_BP: `bp_en` = 0. Both are legal in any state with `cmd_ready` = 1.
- CLR_CNT: `retire_cnt` = 0. A retirement in the same cycle is lost, because clear wins.
- RESET_CORE: go to RESET_HOLD from any accepting state. Clear `hold_cnt`. Breakpoint and counter are unchanged.

## Timing
- `rst_n` low at an edge forces all of the following after that edge:
  - state RESET_HOLD, `hold_cnt` = 0;
  - `core_rst_n` = 0, `core_en` = 0, `cmd_ready` = 0;
  - `halted` = 0, `halt_cause` = 0, `retire_cnt` = 0;
  - `bp_en` = 0, `bp_addr` = 0, `skip_once` = 0, `budget_left` = 0.
- `rst_n` mid-run aborts immediately. There is no drain.
- After `rst_n` rises, `core_rst_n` stays low for exactly RST_HOLD_CYCLES edges. HALTED (or RUNNING) is visible on the following cycle.
- Command latency is 1 cycle.
  - After RUN is accepted at edge N, `core_en` can first be 1 in cycle N+1.
  - STEP yields exactly one `core_en` = 1 cycle (unless a breakpoint or EBREAK stops it). `halted` = 1 in the cycle after that.
- `core_en` never pulses while `core_rst_n` = 0.
- `halted` and `halt_cause` are registered. They update together on the edge that enters HALTED.

## Test plan
- Reset release, RST_HOLD_CYCLES = 4, AUTO_RUN = 0 → `core_rst_n` low for 4 cycles after `rst_n` rises, then `halted` = 1, cause 0, `cmd_ready` = 1, `retire_cnt` = 0.
- RUN with `cmd_data` = 5 from HALTED → exactly 5 `core_en` pulses, `retire_cnt` = 5, then `halted` = 1, cause 5. Repeat 3× STEP → +3 retirements, cause 2 each time.
- SET_BP 0x10, then RUN 0 with code stepping PC by 4 from 0 → `core_en` = 0 when `pc` = 0x10, cause 3, `retire_cnt` = 4. A second RUN 0 → the 0x10 instruction retires, then the PC loops without halting again until it returns to 0x10.
- `instr` = 32'h00100073 at `pc` = 0x08 while running → halt with cause 4 and 2 retirements. Breakpoint at 0x08 set as well → cause 3.
- HALT accepted during RUNNING → the accept-cycle instruction retires, `core_en` = 0 next cycle, cause 1. HALT while HALTED → cause unchanged.
- RESET_CORE mid-run, then `rst_n` low mid-hold → `core_rst_n` held low for the full count after each. `retire_cnt` is preserved across RESET_CORE and zeroed by `rst_n`; CLR_CNT sets it to 0.
